// File: rtl/zcmt_pkg.sv
// zcmt_pkg: shared types and constants for the ZCMT jump-table responder.
//   - zcmt_state_e        : responder FSM states (IDLE, TAG, WAIT)
//   - zcmt_cfg_t          : minimal core configuration (XLEN, PLEN)
//   - zcmt_dcache_req_*_t : two-phase data-cache port request/response
//   - zcmt_addr_ok()      : table range and word-alignment check
package zcmt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_WAIT = 2'd2
  } zcmt_state_e;

  localparam int unsigned ZCMT_TABLE_ENTRIES  = 32'd256;
  // Highest table index reachable by cm.jt; cm.jalt starts above it.
  localparam int unsigned ZCMT_CMJT_MAX_INDEX = 32'd31;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned PLEN;
  } zcmt_cfg_t;

  localparam zcmt_cfg_t ZCMT_CFG_DEFAULT = '{XLEN: 32'd32, PLEN: 32'd34};

  // Port field widths; address_tag + address_index spans PLEN.
  localparam int unsigned ZCMT_IDX_W  = 32'd12;
  localparam int unsigned ZCMT_TAG_W  = 32'd22;
  localparam int unsigned ZCMT_DATA_W = 32'd32;
  localparam int unsigned ZCMT_BE_W   = 32'd4;
  localparam int unsigned ZCMT_ID_W   = 32'd4;

  typedef struct packed {
    logic [ZCMT_IDX_W-1:0]  address_index;
    logic [ZCMT_TAG_W-1:0]  address_tag;
    logic                   data_req;
    logic                   data_we;
    logic [ZCMT_BE_W-1:0]   data_be;
    logic [ZCMT_DATA_W-1:0] data_wdata;
    logic [ZCMT_ID_W-1:0]   data_id;
    logic                   kill_req;
    logic                   tag_valid;
  } zcmt_dcache_req_i_t;

  typedef struct packed {
    logic                   data_gnt;
    logic                   data_rvalid;
    logic [ZCMT_ID_W-1:0]   data_rid;
    logic [ZCMT_DATA_W-1:0] data_rdata;
    logic [0:0]             data_ruser;
  } zcmt_dcache_req_o_t;

  // True when addr lies inside [base, base + 4*entries) and is word aligned.
  // Callers zero-extend their PLEN-bit addresses to 64 bits.
  function automatic logic zcmt_addr_ok(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input int unsigned entries);
    logic [63:0] off;
    off = addr - base;
    return (addr >= base) && (off < (64'(entries) * 64'd4)) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/zcmt_table_ram.sv
// zcmt_table_ram: ENTRIES x XLEN register array backing the jump table.
//   clk_i, rst_i     : clock, async active-high reset (clears every entry)
//   port_*           : byte-enabled write from the cache port
//   side_*           : full-word side-load write; loses to a port write
//                      to the same entry in the same cycle
//   rd_idx_i/rd_data_o : combinational read of the current (pre-write) value
module zcmt_table_ram #(
  parameter int unsigned ENTRIES = 32'd256,
  parameter int unsigned XLEN    = 32'd32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       port_we_i,
  input  logic [$clog2(ENTRIES)-1:0] port_idx_i,
  input  logic [XLEN/8-1:0]          port_be_i,
  input  logic [XLEN-1:0]            port_wdata_i,
  input  logic                       side_we_i,
  input  logic [$clog2(ENTRIES)-1:0] side_idx_i,
  input  logic [XLEN-1:0]            side_wdata_i,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
  output logic [XLEN-1:0]            rd_data_o
);

  localparam int unsigned EW  = $clog2(ENTRIES);
  localparam int unsigned BEW = XLEN / 8;

  logic [XLEN-1:0] mem_q [ENTRIES];
  logic [XLEN-1:0] mem_d [ENTRIES];

  // Next-state of every entry: port write (per byte) beats side-load.
  always_comb begin
    for (int e = 0; e < ENTRIES; e++) begin
      if (port_we_i && (port_idx_i == EW'(e))) begin
        for (int b = 0; b < BEW; b++) begin
          mem_d[e][8*b +: 8] = port_be_i[b] ? port_wdata_i[8*b +: 8] : mem_q[e][8*b +: 8];
        end
      end else if (side_we_i && (side_idx_i == EW'(e))) begin
        mem_d[e] = side_wdata_i;
      end else begin
        mem_d[e] = mem_q[e];
      end
    end
  end

  // Table storage, cleared on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/zcmt_table_responder.sv
// zcmt_table_responder: data-cache-port peer serving ZCMT jump-table fetches.
//   clk_i, rst_i   : clock, async active-high reset
//   req_port_i     : two-phase request (index phase, then tag phase)
//   req_port_o     : gnt (combinational in IDLE), rvalid/rid/rdata LATENCY
//                    cycles after the accepted tag; ruser is always 0
//   gnt_stall_i    : suppresses the grant (arbitration loss)
//   tbl_we_i/tbl_waddr_i/tbl_wdata_i : side-load into the table
//   err_o          : one-cycle pulse on out-of-range or misaligned access
//   busy_o         : FSM not in IDLE
module zcmt_table_responder
  import zcmt_pkg::*;
#(
  parameter zcmt_cfg_t   CVA6Cfg        = ZCMT_CFG_DEFAULT,
  parameter type         dcache_req_i_t = zcmt_dcache_req_i_t,
  parameter type         dcache_req_o_t = zcmt_dcache_req_o_t,
  parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
  parameter int unsigned ENTRIES        = ZCMT_TABLE_ENTRIES,
  parameter int unsigned LATENCY        = 32'd2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  dcache_req_i_t              req_port_i,
  output dcache_req_o_t              req_port_o,
  input  logic                       gnt_stall_i,
  input  logic                       tbl_we_i,
  input  logic [$clog2(ENTRIES)-1:0] tbl_waddr_i,
  input  logic [CVA6Cfg.XLEN-1:0]    tbl_wdata_i,
  output logic                       err_o,
  output logic                       busy_o
);

  localparam int unsigned XLEN = CVA6Cfg.XLEN;
  localparam int unsigned PLEN = CVA6Cfg.PLEN;
  localparam int unsigned EW   = $clog2(ENTRIES);
  localparam int unsigned CW   = (LATENCY > 32'd1) ? $clog2(LATENCY) : 32'd1;
  localparam logic [PLEN-1:0] BASE_P   = PLEN'(BASE_ADDR);
  localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 32'd1);

  zcmt_state_e            state_q, state_d;
  logic [ZCMT_IDX_W-1:0]  idx_q, idx_d;
  logic [ZCMT_ID_W-1:0]   id_q, id_d;
  logic                   we_q, we_d;
  logic [ZCMT_BE_W-1:0]   be_q, be_d;
  logic [XLEN-1:0]        wdata_q, wdata_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [XLEN-1:0]        rdata_q, rdata_d;
  logic                   eflag_q, eflag_d;

  logic            gnt_s, rvalid_s, err_s, port_we_s, valid_s;
  logic [PLEN-1:0] addr_s, off_s;
  logic [EW-1:0]   ent_s;
  logic [XLEN-1:0] rd_data_s;

  // Full address is the live tag joined with the index captured at grant.
  assign addr_s  = PLEN'({req_port_i.address_tag, idx_q});
  assign off_s   = addr_s - BASE_P;
  assign valid_s = zcmt_addr_ok(64'(addr_s), 64'(BASE_P), ENTRIES);
  assign ent_s   = off_s[EW+1:2];

  zcmt_table_ram #(
    .ENTRIES (ENTRIES),
    .XLEN    (XLEN)
  ) u_ram (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .port_we_i    (port_we_s),
    .port_idx_i   (ent_s),
    .port_be_i    (be_q),
    .port_wdata_i (wdata_q),
    .side_we_i    (tbl_we_i),
    .side_idx_i   (tbl_waddr_i),
    .side_wdata_i (tbl_wdata_i),
    .rd_idx_i     (ent_s),
    .rd_data_o    (rd_data_s)
  );

  // FSM next-state, capture registers and port handshakes.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    id_d      = id_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    eflag_d   = eflag_q;
    gnt_s     = 1'b0;
    rvalid_s  = 1'b0;
    err_s     = 1'b0;
    port_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_s = req_port_i.data_req & ~gnt_stall_i;
        if (gnt_s) begin
          idx_d   = req_port_i.address_index;
          id_d    = req_port_i.data_id;
          we_d    = req_port_i.data_we;
          be_d    = req_port_i.data_be;
          wdata_d = req_port_i.data_wdata;
          state_d = ST_TAG;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TAG: begin
        if (req_port_i.kill_req) begin
          state_d = ST_IDLE;
        end else if (!req_port_i.tag_valid) begin
          state_d = ST_TAG;
        end else if (we_q) begin
          port_we_s = valid_s;
          err_s     = ~valid_s;
          state_d   = ST_IDLE;
        end else begin
          // Data is sampled now; later table writes cannot alter it.
          rdata_d = valid_s ? rd_data_s : '0;
          eflag_d = ~valid_s;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (req_port_i.kill_req) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rvalid_s = 1'b1;
          err_s    = eflag_q;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      id_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      eflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      eflag_q <= eflag_d;
    end
  end

  // Response struct; rid/rdata are only presented alongside rvalid.
  always_comb begin
    req_port_o             = '0;
    req_port_o.data_gnt    = gnt_s;
    req_port_o.data_rvalid = rvalid_s;
    req_port_o.data_rid    = rvalid_s ? id_q : '0;
    req_port_o.data_rdata  = rvalid_s ? rdata_q : '0;
    req_port_o.data_ruser  = 1'b0;
  end

  assign err_o  = err_s;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_zcmt_table_responder.sv
module tb_zcmt_table_responder;
  import zcmt_pkg::*;

  localparam int LAT = 2;

  logic               clk = 1'b0;
  logic               rst;
  zcmt_dcache_req_i_t req;
  zcmt_dcache_req_o_t rsp;
  logic               gnt_stall;
  logic               tbl_we;
  logic [7:0]         tbl_waddr;
  logic [31:0]        tbl_wdata;
  logic               err;
  logic               busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  zcmt_table_responder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_port_i  (req),
    .req_port_o  (rsp),
    .gnt_stall_i (gnt_stall),
    .tbl_we_i    (tbl_we),
    .tbl_waddr_i (tbl_waddr),
    .tbl_wdata_i (tbl_wdata),
    .err_o       (err),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sideload(input logic [7:0] idx, input logic [31:0] data);
    tbl_we    = 1'b1;
    tbl_waddr = idx;
    tbl_wdata = data;
    step();
    tbl_we = 1'b0;
  endtask

  // Full read transaction with optional grant stall, tag delay and a
  // side-load to the same entry during the tag cycle.
  task automatic do_read(input string lbl, input logic [33:0] addr, input logic [3:0] id,
                         input int stall, input int tdly, input logic [31:0] exp_data,
                         input logic exp_err, input logic sl_en, input logic [31:0] sl_data);
    logic [33:0] off;
    off = addr - 34'h0_0001_0000;
    req.data_req      = 1'b1;
    req.data_we       = 1'b0;
    req.data_be       = 4'h0;
    req.data_wdata    = 32'h0;
    req.address_index = addr[11:0];
    req.data_id       = id;
    for (int i = 0; i < stall; i++) begin
      gnt_stall = 1'b1;
      #1;
      chk({lbl, ":stall_gnt"}, 64'(rsp.data_gnt), 64'd0);
      step();
    end
    gnt_stall = 1'b0;
    #1;
    chk({lbl, ":gnt"}, 64'(rsp.data_gnt), 64'd1);
    step();
    req.data_req      = 1'b0;
    req.address_index = 12'hFFF;
    req.address_tag   = addr[33:12];
    for (int i = 0; i < tdly; i++) begin
      req.tag_valid = 1'b0;
      #1;
      chk({lbl, ":tag_busy"}, 64'(busy), 64'd1);
      chk({lbl, ":tag_rvalid"}, 64'(rsp.data_rvalid), 64'd0);
      step();
    end
    req.tag_valid = 1'b1;
    tbl_we        = sl_en;
    tbl_waddr     = off[9:2];
    tbl_wdata     = sl_data;
    #1;
    chk({lbl, ":tag_gnt"}, 64'(rsp.data_gnt), 64'd0);
    chk({lbl, ":tag_err"}, 64'(err), 64'd0);
    step();
    req.tag_valid = 1'b0;
    tbl_we        = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      #1;
      chk({lbl, ":early_rvalid"}, 64'(rsp.data_rvalid), 64'd0);
      step();
    end
    #1;
    chk({lbl, ":rvalid"}, 64'(rsp.data_rvalid), 64'd1);
    chk({lbl, ":rdata"}, 64'(rsp.data_rdata), 64'(exp_data));
    chk({lbl, ":rid"}, 64'(rsp.data_rid), 64'(id));
    chk({lbl, ":err"}, 64'(err), 64'(exp_err));
    step();
    #1;
    chk({lbl, ":rvalid_end"}, 64'(rsp.data_rvalid), 64'd0);
    chk({lbl, ":busy_end"}, 64'(busy), 64'd0);
  endtask

  task automatic do_write(input string lbl, input logic [33:0] addr, input logic [3:0] be,
                          input logic [31:0] data, input logic sl_en, input logic [7:0] sl_idx,
                          input logic [31:0] sl_data, input logic exp_err);
    req.data_req      = 1'b1;
    req.data_we       = 1'b1;
    req.data_be       = be;
    req.data_wdata    = data;
    req.data_id       = 4'h0;
    req.address_index = addr[11:0];
    #1;
    chk({lbl, ":gnt"}, 64'(rsp.data_gnt), 64'd1);
    step();
    req.data_req    = 1'b0;
    req.data_we     = 1'b0;
    req.address_tag = addr[33:12];
    req.tag_valid   = 1'b1;
    tbl_we          = sl_en;
    tbl_waddr       = sl_idx;
    tbl_wdata       = sl_data;
    #1;
    chk({lbl, ":err"}, 64'(err), 64'(exp_err));
    chk({lbl, ":rvalid"}, 64'(rsp.data_rvalid), 64'd0);
    step();
    req.tag_valid = 1'b0;
    tbl_we        = 1'b0;
    #1;
    chk({lbl, ":busy_end"}, 64'(busy), 64'd0);
    chk({lbl, ":rvalid_end"}, 64'(rsp.data_rvalid), 64'd0);
    chk({lbl, ":err_end"}, 64'(err), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    gnt_stall = 1'b0;
    tbl_we    = 1'b0;
    tbl_waddr = 8'h0;
    tbl_wdata = 32'h0;
    #2;
    chk("rst:gnt", 64'(rsp.data_gnt), 64'd0);
    chk("rst:rvalid", 64'(rsp.data_rvalid), 64'd0);
    chk("rst:rdata", 64'(rsp.data_rdata), 64'd0);
    chk("rst:rid", 64'(rsp.data_rid), 64'd0);
    chk("rst:err", 64'(err), 64'd0);
    chk("rst:busy", 64'(busy), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Basic read of entry 5.
    sideload(8'd5, 32'h0000_2040);
    do_read("rd5", 34'h0_0001_0014, 4'd1, 0, 0, 32'h0000_2040, 1'b0, 1'b0, 32'h0);
    // Grant held off by stall for 3 cycles.
    do_read("stall", 34'h0_0001_0014, 4'd2, 3, 0, 32'h0000_2040, 1'b0, 1'b0, 32'h0);
    // tag_valid withheld 4 cycles.
    do_read("tdly", 34'h0_0001_0014, 4'd3, 0, 4, 32'h0000_2040, 1'b0, 1'b0, 32'h0);
    // Out of range, misaligned, below base.
    do_read("oor", 34'h0_0001_0400, 4'd4, 0, 0, 32'h0, 1'b1, 1'b0, 32'h0);
    do_read("mis", 34'h0_0001_0002, 4'd5, 0, 0, 32'h0, 1'b1, 1'b0, 32'h0);
    do_read("below", 34'h0_0000_FFFC, 4'd6, 0, 0, 32'h0, 1'b1, 1'b0, 32'h0);
    // Last entry and the cm.jt boundary entry.
    sideload(8'd255, 32'hDEAD_BEEF);
    do_read("last", 34'h0_0001_03FC, 4'd7, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    sideload(8'(ZCMT_CMJT_MAX_INDEX), 32'h0000_1F1F);
    do_read("jtmax", 34'h0_0001_007C, 4'd8, 0, 0, 32'h0000_1F1F, 1'b0, 1'b0, 32'h0);

    // Byte-enabled port write beats a simultaneous side-load.
    sideload(8'd7, 32'h1234_5678);
    do_write("wr7", 34'h0_0001_001C, 4'b0011, 32'hAAAA_BBBB, 1'b1, 8'd7, 32'hCCCC_CCCC, 1'b0);
    do_read("rd7", 34'h0_0001_001C, 4'd9, 0, 0, 32'h1234_BBBB, 1'b0, 1'b0, 32'h0);
    do_write("wr7be0", 34'h0_0001_001C, 4'b0000, 32'hFFFF_FFFF, 1'b0, 8'd0, 32'h0, 1'b0);
    do_write("wroor", 34'h0_0001_0400, 4'b1111, 32'hFFFF_FFFF, 1'b0, 8'd0, 32'h0, 1'b1);
    do_read("rd7b", 34'h0_0001_001C, 4'd10, 0, 0, 32'h1234_BBBB, 1'b0, 1'b0, 32'h0);

    // Side-load to the entry being read in the tag cycle: old value returned.
    do_read("slold", 34'h0_0001_0014, 4'd11, 0, 0, 32'h0000_2040, 1'b0, 1'b1, 32'h0000_5555);
    do_read("slnew", 34'h0_0001_0014, 4'd12, 0, 0, 32'h0000_5555, 1'b0, 1'b0, 32'h0);

    // kill_req in TAG.
    req.data_req      = 1'b1;
    req.data_we       = 1'b0;
    req.address_index = 12'h014;
    req.data_id       = 4'd13;
    #1;
    chk("ktag:gnt", 64'(rsp.data_gnt), 64'd1);
    step();
    req.data_req    = 1'b0;
    req.address_tag = 22'h10;
    req.tag_valid   = 1'b1;
    req.kill_req    = 1'b1;
    #1;
    chk("ktag:err", 64'(err), 64'd0);
    step();
    req.tag_valid = 1'b0;
    req.kill_req  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ktag:rvalid", 64'(rsp.data_rvalid), 64'd0);
      chk("ktag:busy", 64'(busy), 64'd0);
      step();
    end

    // kill_req in WAIT.
    req.data_req = 1'b1;
    req.data_id  = 4'd14;
    #1;
    chk("kwait:gnt", 64'(rsp.data_gnt), 64'd1);
    step();
    req.data_req  = 1'b0;
    req.tag_valid = 1'b1;
    step();
    req.tag_valid = 1'b0;
    req.kill_req  = 1'b1;
    #1;
    chk("kwait:busy_in", 64'(busy), 64'd1);
    chk("kwait:rvalid_in", 64'(rsp.data_rvalid), 64'd0);
    step();
    req.kill_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("kwait:rvalid", 64'(rsp.data_rvalid), 64'd0);
      chk("kwait:busy", 64'(busy), 64'd0);
      step();
    end

    // Reset asserted in the cycle rvalid would fire.
    req.data_req = 1'b1;
    req.data_id  = 4'd15;
    #1;
    chk("rwait:gnt", 64'(rsp.data_gnt), 64'd1);
    step();
    req.data_req  = 1'b0;
    req.tag_valid = 1'b1;
    step();
    req.tag_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("rwait:rvalid", 64'(rsp.data_rvalid), 64'd0);
    chk("rwait:rdata", 64'(rsp.data_rdata), 64'd0);
    chk("rwait:rid", 64'(rsp.data_rid), 64'd0);
    chk("rwait:err", 64'(err), 64'd0);
    chk("rwait:busy", 64'(busy), 64'd0);
    step();
    rst = 1'b0;
    step();
    do_read("postrst5", 34'h0_0001_0014, 4'd1, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0);
    do_read("postrst7", 34'h0_0001_001C, 4'd2, 0, 0, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
